alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 74 +++++++
 rtl/alu_mul_seq.sv | 53 +++++
 rtl/alu_mc.sv | 179 +++++++++++++++++
 tb/tb_alu_mc.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and flag indices for the multi-cycle ALU.
// Also provides a helper that maps an opcode to the operands it requires.
package alu_pkg;

  typedef enum logic [3:0] {
    ARITH_ADD     = 4'b0000,
    ARITH_SUB     = 4'b0001,
    ARITH_ADDC    = 4'b0010,
    ARITH_SUBC    = 4'b0011,
    ARITH_INC_A   = 4'b0100,
    ARITH_DEC_A   = 4'b0101,
    ARITH_INC_B   = 4'b0110,
    ARITH_DEC_B   = 4'b0111,
    ARITH_CMP     = 4'b1000,
    ARITH_MUL_INC = 4'b1001,
    ARITH_MUL_SHL = 4'b1010
  } arith_op_e;

  typedef enum logic [3:0] {
    LOGIC_AND   = 4'b0000,
    LOGIC_NAND  = 4'b0001,
    LOGIC_OR    = 4'b0010,
    LOGIC_NOR   = 4'b0011,
    LOGIC_XOR   = 4'b0100,
    LOGIC_XNOR  = 4'b0101,
    LOGIC_NOT_A = 4'b0110,
    LOGIC_NOT_B = 4'b0111,
    LOGIC_SHR_A = 4'b1000,
    LOGIC_SHL_A = 4'b1001,
    LOGIC_SHR_B = 4'b1010,
    LOGIC_SHL_B = 4'b1011,
    LOGIC_ROL   = 4'b1100,
    LOGIC_ROR   = 4'b1101
  } logic_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  localparam int FLAG_ERR   = 0;
  localparam int FLAG_OFLOW = 1;
  localparam int FLAG_COUT  = 2;
  localparam int FLAG_G     = 3;
  localparam int FLAG_L     = 4;
  localparam int FLAG_E     = 5;
  localparam int NUM_FLAGS  = 6;

  // Returns the VALID mask an opcode needs: 11 two-operand, 01 A-only,
  // 10 B-only, 00 for an unused opcode.
  function automatic logic [1:0] operands_needed(input logic mode, input logic [3:0] cmd);
    logic [1:0] need;
    need = 2'b00;
    if (mode) begin
      case (cmd)
        ARITH_ADD, ARITH_SUB, ARITH_ADDC, ARITH_SUBC,
        ARITH_CMP, ARITH_MUL_INC, ARITH_MUL_SHL: need = 2'b11;
        ARITH_INC_A, ARITH_DEC_A:                need = 2'b01;
        ARITH_INC_B, ARITH_DEC_B:                need = 2'b10;
        default:                                 need = 2'b00;
      endcase
    end else begin
      case (cmd)
        LOGIC_AND, LOGIC_NAND, LOGIC_OR, LOGIC_NOR,
        LOGIC_XOR, LOGIC_XNOR, LOGIC_ROL, LOGIC_ROR: need = 2'b11;
        LOGIC_NOT_A, LOGIC_SHR_A, LOGIC_SHL_A:       need = 2'b01;
        LOGIC_NOT_B, LOGIC_SHR_B, LOGIC_SHL_B:       need = 2'b10;
        default:                                     need = 2'b00;
      endcase
    end
    return need;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per enabled cycle.
// done is combinational and marks the cycle whose edge performs the last step.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               start,
  input  logic [WIDTH:0]     a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH:0]     acc_init,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH:0]   product
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] mcand;
  logic [2*WIDTH:0] partial;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  assign partial = mplier[0] ? mcand : '0;
  assign product = acc + partial;
  assign done    = busy && ce && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (ce) begin
      if (start && !busy) begin
        busy   <= 1'b1;
        acc    <= {{WIDTH{1'b0}}, acc_init};
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        cnt    <= '0;
      end else if (busy) begin
        acc    <= product;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: registered single-cycle arithmetic/logic ops plus two
// multiply flavours executed by an iterative shift-add unit.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   OPA,
  input  logic [WIDTH-1:0]   OPB,
  input  logic               CIN,
  input  logic               CE,
  input  logic               MODE,
  input  logic [3:0]         CMD,
  input  logic [1:0]         VALID,
  output logic               IN_READY,
  output logic [2*WIDTH-1:0] RES,
  output logic               OUT_VALID,
  output logic               ERR,
  output logic               OFLOW,
  output logic               COUT,
  output logic               G,
  output logic               L,
  output logic               E,
  output alu_state_e         fsm_state
);
  // Handshake: an operation is taken on a CLK edge where CE=1, VALID!=00 and
  // IN_READY=1; inputs are ignored otherwise. Each result is a one-cycle
  // OUT_VALID strobe, RES and flags hold until the next result.
  localparam int SHW = $clog2(WIDTH);

  alu_state_e           state, state_nxt;
  logic [2*WIDTH-1:0]   res_q, op_res;
  logic [NUM_FLAGS-1:0] flags_q, op_flags, mul_flags;
  logic [WIDTH:0]       wide, mul_a, mul_init;
  logic [1:0]           need;
  logic                 rot_err, op_is_mul, op_is_mul_inc, mul_inc_q, out_valid_q;
  logic                 in_ready, accept, start_mul, mul_busy, mul_done;
  logic [2*WIDTH:0]     mul_product;
  int unsigned          rot_amt;

  always_comb begin
    op_res        = '0;
    op_flags      = '0;
    op_is_mul     = 1'b0;
    op_is_mul_inc = 1'b0;
    wide          = '0;
    mul_a         = '0;
    mul_init      = '0;
    need          = operands_needed(MODE, CMD);
    rot_amt       = 32'(OPB[SHW-1:0]);
    if (rot_amt >= 32'(WIDTH)) rot_amt = rot_amt - 32'(WIDTH);
    rot_err = !MODE && (CMD == LOGIC_ROL || CMD == LOGIC_ROR) && ((OPB >> SHW) != '0);

    if (need == 2'b00 || (VALID & need) != need || rot_err) begin
      op_flags[FLAG_ERR] = 1'b1;
    end else if (MODE) begin
      case (CMD)
        ARITH_ADD, ARITH_ADDC, ARITH_INC_A, ARITH_INC_B: begin
          if (CMD == ARITH_INC_A)      wide = {1'b0, OPA} + (WIDTH+1)'(1);
          else if (CMD == ARITH_INC_B) wide = {1'b0, OPB} + (WIDTH+1)'(1);
          else wide = {1'b0, OPA} + {1'b0, OPB} + {{WIDTH{1'b0}}, CIN & (CMD == ARITH_ADDC)};
          op_flags[FLAG_COUT] = wide[WIDTH];
          op_res = {{(WIDTH-1){1'b0}}, wide};
        end
        ARITH_SUB, ARITH_SUBC, ARITH_DEC_A, ARITH_DEC_B: begin
          if (CMD == ARITH_DEC_A)      wide = {1'b0, OPA} - (WIDTH+1)'(1);
          else if (CMD == ARITH_DEC_B) wide = {1'b0, OPB} - (WIDTH+1)'(1);
          else wide = {1'b0, OPA} - {1'b0, OPB} - {{WIDTH{1'b0}}, CIN & (CMD == ARITH_SUBC)};
          op_flags[FLAG_OFLOW] = wide[WIDTH];
          op_res = {{WIDTH{1'b0}}, wide[WIDTH-1:0]};
        end
        ARITH_CMP: begin
          op_flags[FLAG_G] = OPA > OPB;
          op_flags[FLAG_L] = OPA < OPB;
          op_flags[FLAG_E] = OPA == OPB;
        end
        ARITH_MUL_INC: begin
          // (A+1)*(B+1) = (A+1)*B + (A+1): seed the accumulator with A+1
          op_is_mul     = 1'b1;
          op_is_mul_inc = 1'b1;
          mul_a         = {1'b0, OPA} + (WIDTH+1)'(1);
          mul_init      = mul_a;
        end
        default: begin
          op_is_mul = 1'b1;
          mul_a     = {1'b0, OPA[WIDTH-2:0], 1'b0};
        end
      endcase
    end else begin
      case (CMD)
        LOGIC_AND:   op_res[WIDTH-1:0] = OPA & OPB;
        LOGIC_NAND:  op_res[WIDTH-1:0] = ~(OPA & OPB);
        LOGIC_OR:    op_res[WIDTH-1:0] = OPA | OPB;
        LOGIC_NOR:   op_res[WIDTH-1:0] = ~(OPA | OPB);
        LOGIC_XOR:   op_res[WIDTH-1:0] = OPA ^ OPB;
        LOGIC_XNOR:  op_res[WIDTH-1:0] = ~(OPA ^ OPB);
        LOGIC_NOT_A: op_res[WIDTH-1:0] = ~OPA;
        LOGIC_NOT_B: op_res[WIDTH-1:0] = ~OPB;
        LOGIC_SHR_A: op_res[WIDTH-1:0] = OPA >> 1;
        LOGIC_SHL_A: op_res[WIDTH-1:0] = OPA << 1;
        LOGIC_SHR_B: op_res[WIDTH-1:0] = OPB >> 1;
        LOGIC_SHL_B: op_res[WIDTH-1:0] = OPB << 1;
        LOGIC_ROL:   op_res[WIDTH-1:0] = WIDTH'(({OPA, OPA} << rot_amt) >> WIDTH);
        default:     op_res[WIDTH-1:0] = WIDTH'({OPA, OPA} >> rot_amt);
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) && !mul_busy;
    accept    = CE && (VALID != 2'b00) && in_ready;
    start_mul = accept && op_is_mul;
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_mul) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST)     state <= ST_IDLE;
    else if (CE) state <= state_nxt;
  end

  always_comb begin
    mul_flags             = '0;
    mul_flags[FLAG_OFLOW] = mul_inc_q && mul_product[2*WIDTH];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      res_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      mul_inc_q   <= 1'b0;
    end else if (!CE) begin
      out_valid_q <= 1'b0;
    end else if (mul_done) begin
      res_q       <= mul_product[2*WIDTH-1:0];
      flags_q     <= mul_flags;
      out_valid_q <= 1'b1;
    end else if (accept && !op_is_mul) begin
      res_q       <= op_res;
      flags_q     <= op_flags;
      out_valid_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
      if (start_mul) mul_inc_q <= op_is_mul_inc;
    end
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk      (CLK),
    .rst      (RST),
    .ce       (CE),
    .start    (start_mul),
    .a        (mul_a),
    .b        (OPB),
    .acc_init (mul_init),
    .busy     (mul_busy),
    .done     (mul_done),
    .product  (mul_product)
  );

  assign IN_READY  = in_ready;
  assign RES       = res_q;
  assign OUT_VALID = out_valid_q;
  assign ERR       = flags_q[FLAG_ERR];
  assign OFLOW     = flags_q[FLAG_OFLOW];
  assign COUT      = flags_q[FLAG_COUT];
  assign G         = flags_q[FLAG_G];
  assign L         = flags_q[FLAG_L];
  assign E         = flags_q[FLAG_E];
  assign fsm_state = state;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed corner cases plus randomized operations checked
// against an integer-arithmetic reference model and an expected-result queue.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W        = 8;
  localparam int MAX_WAIT = 60;

  logic             CLK = 1'b0;
  logic             RST, CIN, CE, MODE;
  logic [W-1:0]     OPA, OPB;
  logic [3:0]       CMD;
  logic [1:0]       VALID;
  logic             IN_READY, OUT_VALID, ERR, OFLOW, COUT, G, L, E;
  logic [2*W-1:0]   RES;
  alu_state_e       fsm_state;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [2*W+5:0]   exp_q[$];
  logic [2*W-1:0]   last_res;

  alu_mc #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .OPA(OPA), .OPB(OPB), .CIN(CIN), .CE(CE),
    .MODE(MODE), .CMD(CMD), .VALID(VALID), .IN_READY(IN_READY), .RES(RES),
    .OUT_VALID(OUT_VALID), .ERR(ERR), .OFLOW(OFLOW), .COUT(COUT),
    .G(G), .L(L), .E(E), .fsm_state(fsm_state)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // fl = {E, L, G, COUT, OFLOW, ERR}
  function automatic void ref_model(input bit mode, input int cmd, input bit [1:0] valid,
                                    input int a, input int b, input bit cin,
                                    output int res, output bit [5:0] fl, output bit is_mul);
    int m, need;
    longint p;
    m = 1 << W;
    res = 0; fl = '0; is_mul = 1'b0; need = 0; p = 0;
    if (mode) begin
      if (cmd <= 3 || (cmd >= 8 && cmd <= 10)) need = 3;
      else if (cmd == 4 || cmd == 5)           need = 1;
      else if (cmd == 6 || cmd == 7)           need = 2;
    end else begin
      if (cmd <= 5 || cmd == 12 || cmd == 13)          need = 3;
      else if (cmd == 6 || cmd == 8 || cmd == 9)       need = 1;
      else if (cmd == 7 || cmd == 10 || cmd == 11)     need = 2;
    end
    if (need == 0 || (int'(valid) & need) != need || (!mode && cmd >= 12 && b >= W)) begin
      fl[0] = 1'b1;
      return;
    end
    if (mode) begin
      case (cmd)
        0: res = a + b;
        1: res = a - b;
        2: res = a + b + int'(cin);
        3: res = a - b - int'(cin);
        4: res = a + 1;
        5: res = a - 1;
        6: res = b + 1;
        7: res = b - 1;
        8: begin fl[3] = a > b; fl[4] = a < b; fl[5] = a == b; end
        9: begin p = longint'(a + 1) * longint'(b + 1); is_mul = 1'b1; end
        default: begin p = longint'((2 * a) % m) * longint'(b); is_mul = 1'b1; end
      endcase
      if (is_mul) begin
        fl[1] = (cmd == 9) && (p >= longint'(m) * m);
        res   = int'(p % (longint'(m) * m));
      end else if (cmd == 0 || cmd == 2 || cmd == 4 || cmd == 6) begin
        fl[2] = res >= m;
      end else if (cmd == 1 || cmd == 3 || cmd == 5 || cmd == 7) begin
        fl[1] = res < 0;
        if (res < 0) res = res + m;
      end
    end else begin
      case (cmd)
        0:  res = a & b;
        1:  res = ~(a & b) & (m - 1);
        2:  res = a | b;
        3:  res = ~(a | b) & (m - 1);
        4:  res = a ^ b;
        5:  res = ~(a ^ b) & (m - 1);
        6:  res = ~a & (m - 1);
        7:  res = ~b & (m - 1);
        8:  res = a >> 1;
        9:  res = (a << 1) & (m - 1);
        10: res = b >> 1;
        11: res = (b << 1) & (m - 1);
        12: res = ((a << b) | (a >> (W - b))) & (m - 1);
        default: res = ((a >> b) | (a << (W - b))) & (m - 1);
      endcase
    end
  endfunction

  // Called at a negedge; returns at the negedge where the result is presented.
  task automatic run_op(input bit mode, input int cmd, input bit [1:0] valid, input int a,
                        input int b, input bit cin, input int pause_at, input int pause_len);
    int exp_res, cyc, low, exp_lat;
    bit [5:0] exp_fl;
    bit is_mul;
    logic [2*W+5:0] item;
    ref_model(mode, cmd, valid, a, b, cin, exp_res, exp_fl, is_mul);
    exp_q.push_back({exp_res[2*W-1:0], exp_fl});
    exp_lat = is_mul ? W + 1 + pause_len : 1;
    MODE = mode; CMD = cmd[3:0]; VALID = valid; OPA = a[W-1:0]; OPB = b[W-1:0]; CIN = cin; CE = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    VALID = 2'b00;
    cyc = 1;
    low = 0;
    while (OUT_VALID !== 1'b1 && cyc < MAX_WAIT) begin
      if (IN_READY === 1'b0) low++;
      if (cyc == pause_at) CE = 1'b0;
      if (cyc == pause_at + pause_len) CE = 1'b1;
      if (is_mul) begin
        MODE = 1'($urandom); CMD = 4'($urandom); VALID = 2'($urandom_range(1, 3));
        OPA = 8'($urandom); OPB = 8'($urandom);
      end
      @(negedge CLK);
      cyc++;
    end
    VALID = 2'b00;
    CE = 1'b1;
    check_eq("latency", 32'(cyc), 32'(exp_lat));
    check_eq("ready_low_cycles", 32'(low), is_mul ? 32'(W + pause_len) : 32'd0);
    check_eq("ready_at_result", 32'(IN_READY), 32'd1);
    if (OUT_VALID === 1'b1) begin
      item = exp_q.pop_front();
      check_eq("res", 32'(RES), 32'(item[2*W+5:6]));
      check_eq("flags", 32'({E, L, G, COUT, OFLOW, ERR}), 32'(item[5:0]));
      last_res = item[2*W+5:6];
    end else begin
      exp_q.delete();
    end
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        CE = 1'b0; VALID = 2'($urandom_range(1, 3)); MODE = 1'($urandom);
        CMD = 4'($urandom); OPA = 8'($urandom); OPB = 8'($urandom);
      end else begin
        CE = 1'b1; VALID = 2'b00;
      end
      @(negedge CLK);
      check_eq("idle_out_valid", 32'(OUT_VALID), 32'd0);
      check_eq("idle_res_hold", 32'(RES), 32'(last_res));
    end
    CE = 1'b1;
    VALID = 2'b00;
  endtask

  task automatic reset_mid_mul();
    int seen;
    seen = 0;
    MODE = 1'b1; CMD = 4'b1001; VALID = 2'b11; OPA = 8'd100; OPB = 8'd77; CE = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    VALID = 2'b00;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_eq("rst_mul_ready", 32'(IN_READY), 32'd1);
    check_eq("rst_mul_out_valid", 32'(OUT_VALID), 32'd0);
    check_eq("rst_mul_res", 32'(RES), 32'd0);
    check_eq("rst_mul_flags", 32'({E, L, G, COUT, OFLOW, ERR}), 32'd0);
    last_res = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (OUT_VALID === 1'b1) seen++;
    end
    check_eq("rst_mul_no_result", 32'(seen), 32'd0);
  endtask

  initial begin
    bit m;
    int c, a, b;
    RST = 1'b1; CE = 1'b0; VALID = 2'b11; MODE = 1'b1; CMD = 4'd0;
    OPA = 8'd5; OPB = 8'd7; CIN = 1'b0;
    last_res = '0;
    repeat (3) @(negedge CLK);
    check_eq("reset_res", 32'(RES), 32'd0);
    check_eq("reset_flags", 32'({E, L, G, COUT, OFLOW, ERR}), 32'd0);
    check_eq("reset_out_valid", 32'(OUT_VALID), 32'd0);
    check_eq("reset_in_ready", 32'(IN_READY), 32'd1);
    check_eq("reset_state", 32'(fsm_state), 32'(ST_IDLE));
    RST = 1'b0; VALID = 2'b00; CE = 1'b1;
    idle_gap(2);

    run_op(1, 4, 2'b01, 255, 0, 0, 0, 0);
    check_eq("inc_a_res", 32'(RES), 32'h0100);
    check_eq("inc_a_cout", 32'(COUT), 32'd1);
    check_eq("inc_a_out_valid", 32'(OUT_VALID), 32'd1);
    idle_gap(2);
    run_op(1, 5, 2'b01, 0, 0, 0, 0, 0);
    check_eq("dec_a_res", 32'(RES), 32'h00FF);
    check_eq("dec_a_oflow", 32'(OFLOW), 32'd1);
    check_eq("dec_a_err", 32'(ERR), 32'd0);
    run_op(1, 9, 2'b11, 64, 63, 0, 0, 0);
    check_eq("mul_inc_res", 32'(RES), 32'h1040);
    check_eq("mul_inc_oflow", 32'(OFLOW), 32'd0);
    idle_gap(1);
    run_op(1, 9, 2'b11, 255, 255, 0, 0, 0);
    check_eq("mul_inc_max_res", 32'(RES), 32'h0000);
    check_eq("mul_inc_max_oflow", 32'(OFLOW), 32'd1);
    run_op(1, 6, 2'b01, 10, 20, 0, 0, 0);
    check_eq("inc_b_err", 32'(ERR), 32'd1);
    check_eq("inc_b_res", 32'(RES), 32'd0);
    run_op(0, 14, 2'b11, 3, 4, 0, 0, 0);
    check_eq("logic_1110_err", 32'(ERR), 32'd1);
    run_op(1, 8, 2'b11, 50, 1, 0, 0, 0);
    check_eq("cmp_gle", 32'({G, L, E}), 32'b100);
    run_op(0, 12, 2'b11, 8'h81, 8, 0, 0, 0);
    run_op(0, 13, 2'b11, 8'h81, 7, 0, 0, 0);
    run_op(1, 3, 2'b11, 0, 0, 1, 0, 0);
    run_op(1, 10, 2'b11, 200, 3, 0, 3, 4);
    idle_gap(2);
    reset_mid_mul();

    for (int n = 0; n < 200; n++) begin
      m = 1'($urandom);
      c = $urandom_range(0, 15);
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if (!m && c >= 12 && $urandom_range(0, 3) != 0) b = $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0)
        run_op(m, c, 2'($urandom_range(1, 3)), a, b, 1'($urandom), $urandom_range(1, 8), $urandom_range(1, 3));
      else
        run_op(m, c, 2'($urandom_range(1, 3)), a, b, 1'($urandom), 0, 0);
      idle_gap($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
